mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between instruction fetch and data load/store.
//  Sits between the core (fetch unit + datapath) and the single-ported memory.
//  Fixed data-over-fetch priority, bounded by a starvation limit.
//  One transaction in flight at a time; all outputs registered.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; byte-mask width is DATA_W/8
//  STARVE_LIMIT   4  max consecutive data grants while a fetch is pending
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  reset      in   1          synchronous, active-high
//  ifReq      in   1          fetch request; held until ifValid
//  ifAddr     in   ADDR_W     fetch address; stable while ifReq
//  ifRdata    out  DATA_W     fetched instruction; valid with ifValid
//  ifValid    out  1          1-cycle fetch completion pulse
//  dReq       in   1          data request; held until dValid
//  dAddr      in   ADDR_W     data address; stable while dReq
//  dWdata     in   DATA_W     store data, already lane-aligned
//  dWMask     in   DATA_W/8   byte write mask; 0 = load
//  dRdata     out  DATA_W     load data (raw word); valid with dValid
//  dValid     out  1          1-cycle data completion pulse
//  memReq     out  1          memory request; held until memAck
//  memAddr    out  ADDR_W     memory address
//  memWdata   out  DATA_W     memory write data
//  memWMask   out  DATA_W/8   memory write mask; 0 for reads and fetches
//  memAck     in   1          memory accepted request this cycle
//  memRvalid  in   1          read data valid (reads only, >=1 cycle after memAck)
//  memRdata   in   DATA_W     read data
// BEHAVIOUR
//  Reset (sync): state=IDLE; memReq, ifValid, dValid = 0; memAddr, memWdata,
//   memWMask, ifRdata, dRdata = 0; streak = 0. Reset mid-transaction abandons it:
//   no valid pulse issued; memory shares this reset.
//  FSM: IDLE -> REQ -> (RESP for reads) -> IDLE.
//   IDLE: if dReq|ifReq, pick owner, register addr/wdata/mask, memReq=1 next cycle -> REQ.
//   REQ:  memReq held, payload stable. On memAck: memReq=0 next cycle;
//         write -> dValid=1 next cycle, -> IDLE; read/fetch -> RESP.
//   RESP: on memRvalid: capture memRdata into ifRdata/dRdata, pulse owner's valid
//         next cycle, -> IDLE. memRvalid outside RESP is ignored.
//  Arbitration (IDLE only): data wins unless ifReq && streak==STARVE_LIMIT, then fetch.
//   Data grant with ifReq high: streak+1 (saturates at STARVE_LIMIT). Data grant with
//   ifReq low: streak unchanged. Fetch grant: streak=0.
//  Requests sampled in the cycle the owner's valid pulses are not re-granted: requester
//   drops req on valid; arbiter returns to IDLE and samples next cycle (1 idle cycle).
//  Min latency, single-cycle memory (memAck in 1st REQ cycle, memRvalid next):
//   req@N -> memReq@N+1 -> RESP@N+2 -> valid@N+3. Store: dValid@N+2.
//  memAck and memRvalid in the same cycle during REQ: memRvalid ignored (protocol error).
//  ifRdata/dRdata hold last captured value until next capture.
// TESTING
//  1 reset held 3 cycles with ifReq=dReq=1 -> memReq, ifValid, dValid stay 0; state IDLE.
//  2 lone ifReq addr 0x100, memAck 1 cycle after memReq, memRvalid 0x00500093 next cycle
//    -> memAddr=0x100, memWMask=0; ifValid 1 cycle, ifRdata=0x00500093.
//  3 ifReq@0x100 and dReq load@0x2004 same cycle -> memAddr 0x2004 first, dValid; then
//    0x100, ifValid; never both valids in one cycle.
//  4 store dAddr 0x2006 dWMask 4'b0100 dWdata 0x00AB0000, memAck delayed 3 cycles
//    -> memReq/payload stable 4 cycles; dValid the cycle after memAck; no RESP wait.
//  5 STARVE_LIMIT=2, dReq and ifReq continuously re-asserted -> grants D,D,F,D,D,F.
//  6 reset during RESP, then stale memRvalid -> next cycle IDLE, memReq=0, no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// data load/store. Data has priority over fetch, except that a pending fetch
// is forced through after STARVE_LIMIT data grants in a row. One transaction
// is in flight at a time, and every output comes straight from a register.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch side
  input  logic                ifReq,
  input  logic [ADDR_W-1:0]   ifAddr,
  output logic [DATA_W-1:0]   ifRdata,
  output logic                ifValid,
  // data side
  input  logic                dReq,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W-1:0]   dWdata,
  input  logic [DATA_W/8-1:0] dWMask,
  output logic [DATA_W-1:0]   dRdata,
  output logic                dValid,
  // memory side
  output logic                memReq,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memWMask,
  input  logic                memAck,
  input  logic                memRvalid,
  input  logic [DATA_W-1:0]   memRdata
);

  localparam int MASK_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner_d, owner_d_nxt;   // 1 = data owns the port
  logic [STREAK_W-1:0] streak, streak_nxt;     // data grants while fetch waits

  logic                mem_req_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic [MASK_W-1:0]   mem_wmask_nxt;
  logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;
  logic                if_valid_nxt, d_valid_nxt;

  logic                grant_fetch;
  logic                is_write;

  // Fetch wins only when data is absent or has used up its streak.
  assign grant_fetch = ifReq && (!dReq || streak == STREAK_MAX);
  assign is_write    = owner_d && (memWMask != '0);

  // Next-state, arbitration and next values of all registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    streak_nxt    = streak;
    mem_req_nxt   = memReq;
    mem_addr_nxt  = memAddr;
    mem_wdata_nxt = memWdata;
    mem_wmask_nxt = memWMask;
    if_rdata_nxt  = ifRdata;
    d_rdata_nxt   = dRdata;
    if_valid_nxt  = 1'b0;
    d_valid_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // While a valid pulse is out, its requester is still holding the old
        // request, so nothing is granted until the next cycle.
        if (!ifValid && !dValid && (ifReq || dReq)) begin
          mem_req_nxt = 1'b1;
          state_nxt   = REQ;
          if (grant_fetch) begin
            owner_d_nxt   = 1'b0;
            mem_addr_nxt  = ifAddr;
            mem_wdata_nxt = '0;
            mem_wmask_nxt = '0;
            streak_nxt    = '0;
          end else begin
            owner_d_nxt   = 1'b1;
            mem_addr_nxt  = dAddr;
            mem_wdata_nxt = dWdata;
            mem_wmask_nxt = dWMask;
            if (ifReq && streak != STREAK_MAX) streak_nxt = streak + 1'b1;
          end
        end
      end

      REQ: begin
        // Stores finish at acceptance. Reads and fetches wait for data, and a
        // memRvalid arriving together with memAck is dropped.
        if (memAck) begin
          mem_req_nxt = 1'b0;
          if (is_write) begin
            d_valid_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt   = RESP;
          end
        end
      end

      RESP: begin
        if (memRvalid) begin
          state_nxt = IDLE;
          if (owner_d) begin
            d_rdata_nxt = memRdata;
            d_valid_nxt = 1'b1;
          end else begin
            if_rdata_nxt = memRdata;
            if_valid_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      streak   <= '0;
      memReq   <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memWMask <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifValid  <= 1'b0;
      dValid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge no matter what order they are written in.
      state    <= state_nxt;
      owner_d  <= owner_d_nxt;
      streak   <= streak_nxt;
      memReq   <= mem_req_nxt;
      memAddr  <= mem_addr_nxt;
      memWdata <= mem_wdata_nxt;
      memWMask <= mem_wmask_nxt;
      ifRdata  <= if_rdata_nxt;
      dRdata   <= d_rdata_nxt;
      ifValid  <= if_valid_nxt;
      dValid   <= d_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven and outputs are
// sampled 1 ns after each rising edge. Expected values are worked out by hand
// for each step.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ifReq, dReq, memAck, memRvalid;
  logic [ADDR_W-1:0] ifAddr, dAddr, memAddr;
  logic [DATA_W-1:0] dWdata, memWdata, memRdata, ifRdata, dRdata;
  logic [MASK_W-1:0] dWMask, memWMask;
  logic              ifValid, dValid, memReq;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifValid(ifValid),
    .dReq(dReq), .dAddr(dAddr), .dWdata(dWdata), .dWMask(dWMask),
    .dRdata(dRdata), .dValid(dValid),
    .memReq(memReq), .memAddr(memAddr), .memWdata(memWdata),
    .memWMask(memWMask), .memAck(memAck), .memRvalid(memRvalid),
    .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant sequence for the starvation test (limit 2): 1 = data, 0 = fetch.
  bit exp_d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; ifReq = 1'b0; dReq = 1'b0; memAck = 1'b0; memRvalid = 1'b0;
    ifAddr = '0; dAddr = '0; dWdata = '0; dWMask = '0; memRdata = '0;

    // 1: reset held with both requests high -> nothing issued
    #1;
    ifReq = 1'b1; dReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {memReq, ifValid, dValid}, 3'b000);
    end
    ifReq = 1'b0; dReq = 1'b0; reset = 1'b0;
    tick();
    check("rst_idle_req", memReq, 1'b0);
    check("rst_payload", {memAddr, memWdata, memWMask}, '0);
    check("rst_rdata", {ifRdata, dRdata}, '0);

    // 2: lone fetch at 0x100, memAck one cycle after memReq
    ifReq = 1'b1; ifAddr = 32'h100;
    tick();
    check("f_req", memReq, 1'b1);
    check("f_addr", memAddr, 32'h100);
    check("f_mask", memWMask, 4'h0);
    tick();
    check("f_req_hold", memReq, 1'b1);
    memAck = 1'b1;
    tick();
    check("f_req_drop", memReq, 1'b0);
    check("f_no_valid_yet", ifValid, 1'b0);
    memAck = 1'b0; memRvalid = 1'b1; memRdata = 32'h0050_0093;
    tick();
    check("f_valid", {ifValid, dValid}, 2'b10);
    check("f_rdata", ifRdata, 32'h0050_0093);
    ifReq = 1'b0; memRvalid = 1'b0;
    tick();
    check("f_pulse_1cyc", ifValid, 1'b0);
    check("f_rdata_hold", ifRdata, 32'h0050_0093);

    // 3: fetch and data load together -> data first, then fetch
    ifReq = 1'b1; ifAddr = 32'h100;
    dReq = 1'b1; dAddr = 32'h2004; dWMask = 4'h0; dWdata = '0;
    tick();
    check("pri_first_addr", memAddr, 32'h2004);
    memAck = 1'b1;
    tick();
    check("pri_resp_valids", {ifValid, dValid}, 2'b00);
    memAck = 1'b0; memRvalid = 1'b1; memRdata = 32'hCAFE_0001;
    tick();
    check("pri_d_valid", {ifValid, dValid}, 2'b01);
    check("pri_d_rdata", dRdata, 32'hCAFE_0001);
    memRvalid = 1'b0;             // dReq still held during the valid cycle
    tick();
    check("pri_idle_gap", {memReq, ifValid, dValid}, 3'b000);
    dReq = 1'b0;
    tick();
    check("pri_second_req", memReq, 1'b1);
    check("pri_second_addr", memAddr, 32'h100);
    memAck = 1'b1;
    tick();
    memAck = 1'b0; memRvalid = 1'b1; memRdata = 32'h0000_0013;
    tick();
    check("pri_f_valid", {ifValid, dValid}, 2'b10);
    check("pri_f_rdata", ifRdata, 32'h0000_0013);
    check("pri_d_hold", dRdata, 32'hCAFE_0001);
    ifReq = 1'b0; memRvalid = 1'b0;
    tick();
    check("pri_done", {memReq, ifValid, dValid}, 3'b000);

    // 4: store with memAck delayed 3 cycles -> payload stable, dValid after ack
    dReq = 1'b1; dAddr = 32'h2006; dWMask = 4'b0100; dWdata = 32'h00AB_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_req_hold", memReq, 1'b1);
      check("st_payload", {memAddr, memWdata, memWMask},
            {32'h2006, 32'h00AB_0000, 4'b0100});
      check("st_no_valid", dValid, 1'b0);
      if (i == 3) memAck = 1'b1;
    end
    tick();
    check("st_valid", {ifValid, dValid}, 2'b01);
    check("st_req_drop", memReq, 1'b0);
    memAck = 1'b0; dReq = 1'b0; dWMask = 4'h0; dWdata = '0;
    memRvalid = 1'b1; memRdata = 32'hDEAD_BEEF;   // stray memRvalid while idle
    tick();
    check("st_pulse_1cyc", dValid, 1'b0);
    memRvalid = 1'b0;
    tick();
    check("stray_rvalid", {memReq, ifValid, dValid}, 3'b000);
    check("stray_rdata", dRdata, 32'hCAFE_0001);

    // 5: both requests held -> D,D,F,D,D,F with STARVE_LIMIT=2
    dReq = 1'b1; dAddr = 32'h3000; ifReq = 1'b1; ifAddr = 32'h400;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("sv_req", memReq, 1'b1);
      check("sv_grant_addr", memAddr, exp_d[g] ? 32'h3000 : 32'h400);
      memAck = 1'b1;
      tick();
      memAck = 1'b0; memRvalid = 1'b1; memRdata = 32'(g + 1);
      tick();
      check("sv_valid", {ifValid, dValid}, exp_d[g] ? 2'b01 : 2'b10);
      memRvalid = 1'b0;
      tick();
      check("sv_gap", memReq, 1'b0);
    end
    dReq = 1'b0; ifReq = 1'b0;
    tick();

    // 6: reset during RESP, then a stale memRvalid -> nothing happens
    dReq = 1'b1; dAddr = 32'h5000;
    tick();
    check("rr_req", memReq, 1'b1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0; reset = 1'b1; dReq = 1'b0;
    tick();
    check("rr_outs", {memReq, ifValid, dValid}, 3'b000);
    check("rr_rdata_clr", {ifRdata, dRdata}, '0);
    reset = 1'b0; memRvalid = 1'b1; memRdata = 32'h1234_5678;
    tick();
    check("rr_stale", {memReq, ifValid, dValid}, 3'b000);
    memRvalid = 1'b0;
    tick();
    check("rr_stale_after", {memReq, ifValid, dValid, dRdata}, '0);
    ifReq = 1'b1; ifAddr = 32'h600;
    tick();
    check("rr_idle_grant", {memReq, memAddr}, {1'b1, 32'h600});
    ifReq = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
